// File: rtl/doorlock_2.sv
// Three-digit keypad lock: accepts PASS_A or PASS_B, edge-triggered keys, x starts/confirms entry.
// LEDs update on the edge that first samples x high; button_on echoes num one cycle late; no backpressure.
module doorlock_2 #(
    parameter logic [11:0] PASS_A = 12'h529,
    parameter logic [11:0] PASS_B = 12'h579
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] num,
    input  logic       x,
    output logic       out_led_1,
    output logic       out_led_2,
    output logic [9:0] button_on
);
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_RESULT} state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_buf, w_buf_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        r_led1, w_led1_nxt;
    logic        r_led2, w_led2_nxt;
    logic [9:0]  r_btn;
    logic [9:0]  r_num_d;
    logic        r_x_d;

    logic        w_x_rise;
    logic [9:0]  w_num_rise;
    logic        w_one_hot;
    logic [3:0]  w_digit;
    logic        w_match;

    assign w_x_rise   = x & ~r_x_d;
    assign w_num_rise = num & ~r_num_d;
    assign w_one_hot  = (w_num_rise != 10'd0) && ((w_num_rise & (w_num_rise - 10'd1)) == 10'd0);
    assign w_match    = (r_cnt == 3'd3) && !r_err && ((r_buf == PASS_A) || (r_buf == PASS_B));

    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (w_num_rise[k]) w_digit = 4'(k);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_led1_nxt  = r_led1;
        w_led2_nxt  = r_led2;
        case (r_state)
            S_IDLE: begin
                w_led1_nxt = 1'b0;
                w_led2_nxt = 1'b0;
                if (w_x_rise) begin
                    w_state_nxt = S_ENTRY;
                    w_buf_nxt   = 12'd0;
                    w_cnt_nxt   = 3'd0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_ENTRY: begin
                // x wins over a simultaneous digit: compare the buffer as it stood
                if (w_x_rise) begin
                    w_led1_nxt  = w_match;
                    w_led2_nxt  = !w_match;
                    w_state_nxt = S_RESULT;
                end else if (w_num_rise != 10'd0) begin
                    if (w_one_hot) begin
                        w_buf_nxt = {r_buf[7:0], w_digit};
                        if (r_cnt != 3'd4) w_cnt_nxt = r_cnt + 3'd1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_RESULT: begin
                if (w_x_rise) begin
                    w_state_nxt = S_ENTRY;
                    w_led1_nxt  = 1'b0;
                    w_led2_nxt  = 1'b0;
                    w_buf_nxt   = 12'd0;
                    w_cnt_nxt   = 3'd0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_led1_nxt  = 1'b0;
                w_led2_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_buf   <= 12'd0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
            r_led1  <= 1'b0;
            r_led2  <= 1'b0;
            r_btn   <= 10'd0;
            r_num_d <= 10'd0;
            r_x_d   <= 1'b0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_led1  <= w_led1_nxt;
            r_led2  <= w_led2_nxt;
            r_btn   <= (w_state_nxt == S_ENTRY) ? num : 10'd0;
            r_num_d <= num;
            r_x_d   <= x;
        end
    end

    assign out_led_1 = r_led1;
    assign out_led_2 = r_led2;
    assign button_on = r_btn;
endmodule

// File: tb/tb_doorlock_2.sv
// Bench for doorlock_2: directed keypad sessions plus randomized sessions against a digit-list model.
module tb_doorlock_2;
    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] num;
    logic       x;
    logic       out_led_1;
    logic       out_led_2;
    logic [9:0] button_on;

    int n_checks = 0;
    int n_errors = 0;

    doorlock_2 #(.PASS_A(12'h529), .PASS_B(12'h579)) dut (
        .clock     (clock),
        .reset     (reset),
        .num       (num),
        .x         (x),
        .out_led_1 (out_led_1),
        .out_led_2 (out_led_2),
        .button_on (button_on)
    );

    always #5 clock = ~clock;

    // Model: mode 0 idle, 1 entering, 2 showing result; digits kept as a plain list
    int         m_mode;
    int         m_digs[$];
    bit         m_err;
    bit         m_l1, m_l2;
    logic [9:0] m_btn;
    logic [9:0] m_pn;
    bit         m_px;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rv, input bit xv, input logic [9:0] nv);
        bit         xr;
        logic [9:0] nr;
        int         code;
        bit         ok;
        if (!rv) begin
            m_mode = 0; m_digs.delete(); m_err = 0;
            m_l1 = 0; m_l2 = 0; m_btn = '0; m_pn = '0; m_px = 0;
            return;
        end
        xr = xv && !m_px;
        nr = nv & ~m_pn;
        case (m_mode)
            0: if (xr) begin m_mode = 1; m_digs.delete(); m_err = 0; end
            1: begin
                if (xr) begin
                    ok = 0;
                    if (m_digs.size() == 3 && !m_err) begin
                        code = m_digs[0] * 100 + m_digs[1] * 10 + m_digs[2];
                        ok = (code == 529) || (code == 579);
                    end
                    m_l1 = ok; m_l2 = !ok; m_mode = 2;
                end else if (nr != 0) begin
                    if ($countones(nr) == 1) begin
                        for (int k = 0; k < 10; k++) if (nr[k]) m_digs.push_back(k);
                    end else m_err = 1;
                end
            end
            default: if (xr) begin m_mode = 1; m_l1 = 0; m_l2 = 0; m_digs.delete(); m_err = 0; end
        endcase
        m_btn = (m_mode == 1) ? nv : '0;
        m_pn = nv;
        m_px = xv;
    endtask

    task automatic step(input logic rv, input logic xv, input logic [9:0] nv);
        @(negedge clock);
        reset = rv; x = xv; num = nv;
        @(posedge clock);
        model_edge(rv, xv, nv);
        #1;
        chk("led1", 32'(out_led_1), 32'(m_l1));
        chk("led2", 32'(out_led_2), 32'(m_l2));
        chk("button_on", 32'(button_on), 32'(m_btn));
        chk("leds_exclusive", 32'(out_led_1 & out_led_2), 0);
    endtask

    task automatic press(input int d, input int hold, input int gap);
        logic [9:0] v;
        v = 10'(1 << d);
        repeat (hold) step(1'b1, 1'b0, v);
        repeat (gap) step(1'b1, 1'b0, 10'd0);
    endtask

    task automatic xpulse();
        step(1'b1, 1'b1, 10'd0);
        step(1'b1, 1'b0, 10'd0);
    endtask

    task automatic press_btn(input int d, input logic [9:0] exp_btn, input string tag);
        logic [9:0] v;
        v = 10'(1 << d);
        step(1'b1, 1'b0, v);
        chk(tag, 32'(button_on), 32'(exp_btn));
        repeat (4) step(1'b1, 1'b0, v);
        repeat (5) step(1'b1, 1'b0, 10'd0);
    endtask

    task automatic enter3(input int a, input int b, input int c);
        xpulse();
        press(a, 3, 2); press(b, 3, 2); press(c, 3, 2);
        xpulse();
    endtask

    initial begin
        int kind, nd;
        reset = 1'b0; x = 1'b0; num = 10'd0;
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        chk("reset_led1", 32'(out_led_1), 0);
        chk("reset_led2", 32'(out_led_2), 0);
        chk("reset_btn", 32'(button_on), 0);
        press_btn(5, 10'd0, "idle_btn_ignored");
        chk("idle_no_led", 32'(out_led_1 | out_led_2), 0);

        xpulse();
        press_btn(5, 10'h020, "btn_digit5");
        press_btn(2, 10'h004, "btn_digit2");
        press_btn(9, 10'h200, "btn_digit9");
        step(1'b1, 1'b1, 10'd0);
        chk("unlock529_led1", 32'(out_led_1), 1);
        chk("unlock529_led2", 32'(out_led_2), 0);
        step(1'b1, 1'b0, 10'd0);

        step(1'b1, 1'b1, 10'd0);
        chk("result_x_clears", 32'(out_led_1 | out_led_2), 0);
        step(1'b1, 1'b0, 10'd0);
        press(5, 5, 5); press(7, 5, 5); press(9, 5, 5);
        xpulse();
        chk("unlock579", 32'(out_led_1), 1);

        enter3(3, 4, 9);
        chk("reject349_led2", 32'(out_led_2), 1);
        chk("reject349_led1", 32'(out_led_1), 0);
        enter3(5, 1, 6);
        chk("reject516", 32'(out_led_2), 1);

        xpulse(); press(5, 3, 2); press(2, 3, 2); xpulse();
        chk("two_digits", 32'(out_led_2), 1);
        xpulse(); press(5, 3, 2); press(2, 3, 2); press(9, 3, 2); press(9, 3, 2); xpulse();
        chk("four_digits", 32'(out_led_2), 1);
        xpulse(); press(5, 3, 2);
        step(1'b1, 1'b0, 10'h024); step(1'b1, 1'b0, 10'd0);
        press(9, 3, 2); xpulse();
        chk("multi_bit", 32'(out_led_2), 1);

        repeat (4) step(1'b1, 1'b1, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        press(5, 10, 2); press(2, 3, 2); press(9, 3, 2); xpulse();
        chk("held_x_held_digit", 32'(out_led_1), 1);

        xpulse(); press(5, 3, 2); press(2, 3, 2);
        step(1'b0, 1'b0, 10'd0);
        chk("reset_mid_entry", 32'(out_led_1 | out_led_2 | 32'(button_on)), 0);
        step(1'b1, 1'b0, 10'd0);
        enter3(5, 2, 9);
        chk("unlock_after_reset", 32'(out_led_1), 1);

        for (int s = 0; s < 250; s++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0: enter3(5, 2, 9);
                1: enter3(5, 7, 9);
                2: enter3($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
                3, 4: begin
                    nd = (kind == 3) ? 2 : 4;
                    xpulse();
                    for (int i = 0; i < nd; i++)
                        press($urandom_range(0, 9), $urandom_range(1, 3), $urandom_range(1, 2));
                    xpulse();
                end
                5: begin
                    xpulse();
                    press(5, 2, 1);
                    step(1'b1, 1'b0, 10'($urandom_range(1, 1023)));
                    step(1'b1, 1'b0, 10'd0);
                    press(2, 2, 1); press(9, 2, 1);
                    xpulse();
                end
                6: begin
                    repeat ($urandom_range(5, 15))
                        step(1'b1, 1'($urandom_range(0, 3) == 0),
                             ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 1023))
                                                         : 10'(1 << $urandom_range(0, 9)));
                    step(1'b1, 1'b0, 10'd0);
                end
                default: begin
                    xpulse(); press($urandom_range(0, 9), 2, 1);
                    if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 10'd0);
                    step(1'b1, 1'b0, 10'd0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
